// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
// Final ALU pipeline stage: checks the ARM condition code against the
// architectural flags, updates the flags on S-suffixed passing instructions,
// and queues every accepted instruction in a 2-entry in-order buffer that
// feeds the register file. Condition-failed instructions are kept in order
// with their write enable cleared, and counted in squash_cnt.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready = !rst && occupancy < 2)
//   in_F, in_NZCV      ALU result and flags {N,Z,C,V}
//   in_S, in_cond      flag-update request, condition code
//   in_rd, in_wb_en    destination register index and write request
//   out_valid/ready    downstream handshake, head of the buffer
//   out_F, out_rd      head entry result and destination
//   out_we             head entry write enable after the condition check
//   nzcv               architectural flag register {N,Z,C,V}
//   squash_cnt         saturating count of condition-failed instructions
// ---------------------------------------------------------------------------
module alu_writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_F,
  input  logic [3:0]  in_NZCV,
  input  logic        in_S,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_rd,
  input  logic        in_wb_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_F,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output logic [3:0]  nzcv,
  output logic [7:0]  squash_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] f;
    logic [RW-1:0] rd;
    logic          we;
  } entry_t;

  // Slot 0 is always the head; slot 1 is only valid when slot 0 is.
  entry_t        r_slot0;
  entry_t        r_slot1;
  logic          r_vld0;
  logic          r_vld1;
  logic [FW-1:0] r_nzcv;
  logic [CW-1:0] r_squash;

  logic          w_pass;
  logic          w_push;
  logic          w_pop;
  entry_t        w_new;
  logic          w_n;
  logic          w_z;
  logic          w_c;
  logic          w_v;

  assign w_n = r_nzcv[3];
  assign w_z = r_nzcv[2];
  assign w_c = r_nzcv[1];
  assign w_v = r_nzcv[0];

  // ARM condition evaluation against the current flag register.
  always_comb begin
    w_pass = 1'b0;
    case (in_cond)
      4'h0: w_pass = w_z;
      4'h1: w_pass = ~w_z;
      4'h2: w_pass = w_c;
      4'h3: w_pass = ~w_c;
      4'h4: w_pass = w_n;
      4'h5: w_pass = ~w_n;
      4'h6: w_pass = w_v;
      4'h7: w_pass = ~w_v;
      4'h8: w_pass = w_c & ~w_z;
      4'h9: w_pass = ~w_c | w_z;
      4'hA: w_pass = (w_n == w_v);
      4'hB: w_pass = (w_n != w_v);
      4'hC: w_pass = ~w_z & (w_n == w_v);
      4'hD: w_pass = w_z | (w_n != w_v);
      4'hE: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  // Full means slot 1 occupied; readiness never looks at out_ready.
  assign in_ready = ~rst & ~r_vld1;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = r_vld0 & out_ready;

  assign w_new.f  = in_F;
  assign w_new.rd = in_rd;
  assign w_new.we = in_wb_en & w_pass;

  // Two-slot in-order buffer with head in slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
    end else if (w_pop) begin
      if (r_vld1) begin
        // Full: shift forward; no push is possible this cycle.
        r_slot0 <= r_slot1;
        r_vld1  <= 1'b0;
      end else if (w_push) begin
        r_slot0 <= w_new;
      end else begin
        // Head retains its last value so outputs stay X-free.
        r_vld0  <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_vld0) begin
        r_slot0 <= w_new;
        r_vld0  <= 1'b1;
      end else begin
        r_slot1 <= w_new;
        r_vld1  <= 1'b1;
      end
    end
  end

  // Architectural flags and squash counter, both updated at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nzcv   <= '0;
      r_squash <= '0;
    end else if (w_push) begin
      if (w_pass && in_S) begin
        r_nzcv <= in_NZCV;
      end
      if (!w_pass && (r_squash != '1)) begin
        r_squash <= r_squash + CW'(1);
      end
    end
  end

  assign out_valid  = r_vld0;
  assign out_F      = r_slot0.f;
  assign out_rd     = r_slot0.rd;
  assign out_we     = r_slot0.we;
  assign nzcv       = r_nzcv;
  assign squash_cnt = r_squash;

endmodule
